// File: rtl/rs232_tx_buffered_if.sv
// Byte-stream handshake into the buffered RS-232 transmitter.
//   data  : byte to transmit (DATA_BITS wide)
//   valid : source has a byte on data
//   ready : sink holding register is empty; a transfer occurs on valid & ready at a rising edge
// master : byte source, slave : transmitter.
interface rs232_tx_buffered_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rs232_tx_buffered.sv
// RS-232 transmitter with a one-entry holding register in front of the shifter, so a frame can
// follow the previous one with no idle gap. Frame: start, data LSB-first, optional parity, stop(s).
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous reset, active high
//   bus    : byte handshake (slave side); ready = holding register empty
//   TXD_o  : serial line, registered, idles high
//   busy_o : high from first start-bit cycle to last stop-bit cycle on the line
//   done_o : one-cycle pulse on the final cycle of the last stop bit
module rs232_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rs232_tx_buffered_if.slave bus,
  output logic               TXD_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = 3;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  clk_last;
  logic                  load;

  assign bus.ready = ~hold_full_q;
  assign clk_last  = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

  // Line outputs are computed from the current state and registered, so the line lags the
  // FSM by one cycle and is glitch-free.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_last ? '0 : clk_cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    txd_d     = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d    = 1'b0;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        txd_d = 1'b0;
        if (clk_last) state_d = StData;
      end
      StData: begin
        txd_d = shift_q[0];
        if (clk_last) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        txd_d = parity_q;
        if (clk_last) state_d = StStop;
      end
      StStop: begin
        if (clk_last) begin
          if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // A waiting byte starts its frame straight after this stop bit.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (load) begin
      shift_d  = hold_q;
      parity_d = (^hold_q) ^ (PARITY_ODD != 0);
    end
  end

  // Load and drain of the holding register never coincide: it fills only when empty.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (bus.valid && !hold_full_q) begin
      hold_d      = bus.data;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign TXD_o  = txd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_rs232_tx_buffered.sv
// Bench for rs232_tx_buffered: three instances (8N1, 8E1, 8O2) share one stimulus process that
// also compares every output against a frame-level model each cycle, plus literal checks.
module tb_rs232_tx_buffered;

  localparam int N   = 3;
  localparam int CPB = 5;
  localparam int NONE = -1000000;
  localparam logic [N-1:0] PE_V  = 3'b110;
  localparam logic [N-1:0] PO_V  = 3'b100;
  localparam logic [N-1:0] SB2_V = 3'b100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] valid;
  logic [7:0]   data;
  wire  [N-1:0] ready, txd, busy, done;

  always #10 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rs232_tx_buffered_if #(.DATA_BITS(8)) bus ();
    assign bus.data  = data;
    assign bus.valid = valid[g];
    assign ready[g]  = bus.ready;
    rs232_tx_buffered #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY_EN   (int'(PE_V[g])),
      .PARITY_ODD  (int'(PO_V[g])),
      .STOP_BITS   (1 + int'(SB2_V[g]))
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus),
      .TXD_o (txd[g]),
      .busy_o(busy[g]),
      .done_o(done[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: per instance the two most recent frames (start edge, byte) and the handshake state.
  bit         m_ready [N];
  int         drain [N];
  int         a_s [N];
  int         b_s [N];
  logic [7:0] a_d [N];
  logic [7:0] b_d [N];
  logic [N-1:0] last_acc;
  int         acc_cyc [N];

  // Line decoder on instance 0.
  bit         rx_en = 1'b0;
  bit         rx_busy = 1'b0;
  int         rx_f;
  logic [7:0] rx_byte;
  logic       prev_txd = 1'b1;
  int         rx_ferr = 0;
  logic [7:0] rx_q[$];

  function automatic int flen(int i);
    return (10 + int'(PE_V[i]) + int'(SB2_V[i])) * CPB;
  endfunction

  // {txd, busy, done} produced by frame (s, d) on the line after edge c.
  function automatic logic [2:0] frame_out(int i, int s, logic [7:0] d, int c);
    int o;
    int b;
    logic v;
    o = c - s;
    if (o < 0 || o >= flen(i)) return 3'b100;
    b = o / CPB;
    if (b == 0) v = 1'b0;
    else if (b <= 8) v = d[3'(b - 1)];
    else if (b == 9 && PE_V[i]) v = (^d) ^ PO_V[i];
    else v = 1'b1;
    return {v, 1'b1, o == flen(i) - 1};
  endfunction

  function automatic logic [2:0] exp_out(int i, int c);
    logic [2:0] r;
    r = frame_out(i, b_s[i], b_d[i], c);
    if (r[1]) return r;
    return frame_out(i, a_s[i], a_d[i], c);
  endfunction

  task automatic check(string name, int i, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %b want %b", name, i, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(output logic [N-1:0] acc);
    int st;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_ready[i] = 1'b1;
        drain[i]   = -1;
        a_s[i]     = NONE;
        b_s[i]     = NONE;
      end else begin
        acc[i] = valid[i] && m_ready[i];
        if (drain[i] == cyc) m_ready[i] = 1'b1;
        if (acc[i]) begin
          st = cyc + 2;
          if (b_s[i] + flen(i) > st) st = b_s[i] + flen(i);
          a_s[i]     = b_s[i];
          a_d[i]     = b_d[i];
          b_s[i]     = st;
          b_d[i]     = data;
          drain[i]   = st - 1;
          m_ready[i] = 1'b0;
          acc_cyc[i] = cyc;
        end
      end
    end
  endtask

  task automatic rx_sample();
    int o;
    int b;
    if (rx_en) begin
      if (!rx_busy && prev_txd === 1'b1 && txd[0] === 1'b0) begin
        rx_busy = 1'b1;
        rx_f    = cyc;
      end
      if (rx_busy) begin
        o = cyc - rx_f;
        if (o % CPB == 2) begin
          b = o / CPB;
          if (b >= 1 && b <= 8) rx_byte[3'(b - 1)] = txd[0];
          if (b == 9) begin
            if (txd[0] !== 1'b1) rx_ferr++;
            rx_q.push_back(rx_byte);
            rx_busy = 1'b0;
          end
        end
      end
    end
    prev_txd = txd[0];
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [2:0] e;
    logic [N-1:0] acc;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e = exp_out(i, cyc);
        check("txd", i, txd[i], e[2]);
        check("busy", i, busy[i], e[1]);
        check("done", i, done[i], e[0]);
        check("ready", i, ready[i], m_ready[i]);
      end
    end
    rx_sample();
    @(posedge clk);
    cyc++;
    model_edge(acc);
    last_acc = acc;
    #1;
  endtask

  task automatic run_to(int t);
    while (cyc < t) step();
  endtask

  task automatic send(logic [7:0] d, logic [N-1:0] mask);
    logic [N-1:0] pend;
    int n;
    data  = d;
    pend  = mask;
    valid = pend;
    n     = 0;
    while (pend != '0 && n < 300) begin
      step();
      pend  = pend & ~last_acc;
      valid = pend;
      n++;
    end
    if (pend != '0) check_int("send_timeout", int'(pend), 0);
    valid = '0;
  endtask

  task automatic wait_idle();
    bit idle;
    int n;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 3000) begin
      step();
      idle = 1'b1;
      for (int i = 0; i < N; i++)
        if (!m_ready[i] || cyc < b_s[i] + flen(i)) idle = 1'b0;
      n++;
    end
    if (!idle) check_int("idle_timeout", n, 0);
    repeat (3) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k1, k2, s, dcnt, dat;
    logic [9:0]  exp45;
    logic [7:0]  e1e;
    logic [7:0]  codes [16];
    codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    valid = '0;
    data  = '0;
    for (int i = 0; i < N; i++) begin
      m_ready[i] = 1'b1;
      drain[i]   = -1;
      a_s[i]     = NONE;
      b_s[i]     = NONE;
      a_d[i]     = '0;
      b_d[i]     = '0;
      acc_cyc[i] = 0;
    end

    // Reset for three cycles, then idle.
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_txd", 0, txd[0], 1'b1);
    check("rst_ready", 0, ready[0], 1'b1);
    check("rst_busy", 0, busy[0], 1'b0);
    check("rst_done", 0, done[0], 1'b0);
    repeat (20) step();

    // Single byte 0x45: line at bit centres 0, 1,0,1,0,0,0,1,0, 1.
    send(8'h45, 3'b111);
    k = cyc;
    run_to(k + 1);
    check("pre_fall", 0, txd[0], 1'b1);
    run_to(k + 2);
    check("fall", 0, txd[0], 1'b0);
    exp45 = 10'b1010001010;
    for (int b = 0; b < 10; b++) begin
      run_to(k + 2 + CPB * b + 2);
      check("bit45", 0, txd[0], exp45[b]);
    end
    dcnt = 0;
    dat  = -1;
    for (int t = k + 50; t <= k + 60; t++) begin
      run_to(t);
      if (done[0] === 1'b1) begin
        dcnt++;
        dat = t;
      end
    end
    check_int("done_count", dcnt, 1);
    check_int("done_at", dat, k + 51);
    wait_idle();

    // 0x1E: data bits, even/odd parity, 55- and 60-cycle frames.
    send(8'h1E, 3'b111);
    k = cyc;
    s = k + 2;
    e1e = 8'b0001_1110;
    for (int b = 0; b < 8; b++) begin
      run_to(s + CPB * (b + 1) + 2);
      check("bit1e", 0, txd[0], e1e[b]);
    end
    run_to(s + 47);
    check("par_even", 1, txd[1], 1'b0);
    check("par_odd", 2, txd[2], 1'b1);
    run_to(s + 50);
    check("stop2_first", 2, txd[2], 1'b1);
    check("stop2_busy", 2, busy[2], 1'b1);
    run_to(s + 53);
    check("p_done_early", 1, done[1], 1'b0);
    run_to(s + 54);
    check("p_done", 1, done[1], 1'b1);
    run_to(s + 55);
    check("p_end_busy", 1, busy[1], 1'b0);
    run_to(s + 58);
    check("s2_done_early", 2, done[2], 1'b0);
    run_to(s + 59);
    check("s2_done", 2, done[2], 1'b1);
    check("s2_txd", 2, txd[2], 1'b1);
    run_to(s + 60);
    check("s2_end_busy", 2, busy[2], 1'b0);
    wait_idle();

    // Back-to-back 0x16 then 0x1E with valid held.
    send(8'h16, 3'b111);
    k1 = acc_cyc[0];
    send(8'h1E, 3'b111);
    k2 = acc_cyc[0];
    check_int("b2b_second_xfer", k2, k1 + 2);
    run_to(k1 + 50);
    check("b2b_ready_low", 0, ready[0], 1'b0);
    run_to(k1 + 51);
    check("b2b_drain_ready", 0, ready[0], 1'b1);
    check("b2b_last_stop", 0, txd[0], 1'b1);
    check("b2b_done", 0, done[0], 1'b1);
    run_to(k1 + 52);
    check("b2b_start", 0, txd[0], 1'b0);
    check("b2b_busy", 0, busy[0], 1'b1);
    wait_idle();

    // Reset during data bit 3 of 0x9E.
    send(8'h9E, 3'b111);
    k = cyc;
    run_to(k + 2 + CPB * 4 + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_txd", 0, txd[0], 1'b1);
    check("mid_rst_ready", 0, ready[0], 1'b1);
    check("mid_rst_busy", 0, busy[0], 1'b0);
    dcnt = 0;
    for (int t = 0; t < 60; t++) begin
      if (done[0] === 1'b1) dcnt++;
      step();
    end
    check_int("mid_rst_no_done", dcnt, 0);

    // 0x26 after the reset, then the 16 scan codes back-to-back, decoded off the line.
    rx_en = 1'b1;
    send(8'h26, 3'b001);
    wait_idle();
    for (int j = 0; j < 16; j++) send(codes[j], 3'b001);
    wait_idle();
    check_int("rx_count", rx_q.size(), 17);
    check_int("rx_ferr", rx_ferr, 0);
    if (rx_q.size() == 17) begin
      check_int("rx_0x26", int'(rx_q[0]), 32'h26);
      for (int j = 0; j < 16; j++) check_int("rx_code", int'(rx_q[j + 1]), int'(codes[j]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
